mac_seq: RTL and testbench
==========================

# mac_seq

Input sequencer and result collector for the team's saturating multiply-accumulate unit. Accepts a stream of signed operand pairs over a valid/ready handshake, drives the MAC's `in0`/`in1`/`valid_input`/`clear_acc` inputs, and reads back the accumulator after a programmed number of pairs. It then presents the dot-product result on a valid/ready output handshake. It sits between operand memories/FIFOs and one MAC instance with matching `INW`/`OUTW`.

## Interface
- `INW`, 16, operand width (signed two's complement).
- `OUTW`, 48, accumulator/result width; must equal the MAC's `OUTW`.
- `MAXLEN`, 256, maximum pairs per dot product.
- `LENW` (localparam), `$clog2(MAXLEN+1)`, width of length/count.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `start` in 1: begin a dot product; sampled only in IDLE.
- `cfg_len` in LENW: pair count, sampled with `start`; 0 is treated as 1, values >MAXLEN are clamped to MAXLEN.
- `in_valid` in 1, `in_ready` out 1: operand handshake.
- `in_a`, `in_b` in INW signed: operand pair.
- `mac_in0`, `mac_in1` out INW signed: to MAC `in0`/`in1`.
- `mac_valid_input` out 1, `mac_clear_acc` out 1: to MAC.
- `mac_out` in OUTW signed: MAC accumulator.
- `out_valid` out 1, `out_ready` in 1: result handshake.
- `out_data` out OUTW signed: captured result.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- States: IDLE, CLEAR, ACCUM, FLUSH, CAPTURE, OUT.
- IDLE: `start`=1 → latch length `len`, zero `count` → CLEAR. Otherwise stay.
- CLEAR: one cycle, `mac_clear_acc`=1 → ACCUM.
- ACCUM: `in_ready`=1. On handshake, register `in_a`/`in_b` into `mac_in0`/`mac_in1`, set `mac_valid_input`=1 for the next cycle, and increment `count`. With no handshake, `mac_valid_input`=0 next cycle. The handshake that makes `count`=`len` → FLUSH.
- FLUSH: `in_ready`=0. The final pair is presented, so `mac_valid_input`=1 → CAPTURE.
- CAPTURE: `mac_out` holds the final sum. Set `out_data` <= `mac_out` at the cycle's end and `mac_clear_acc`=1 during this cycle → OUT.
- OUT: `out_valid`=1 and `out_data` stable until `out_ready`=1. On that edge → IDLE.
- `start` outside IDLE is ignored. `in_valid` outside ACCUM is ignored (no handshake).
- No arithmetic is performed here. The MAC saturates, and `out_data` is the MAC value bit-exact.
- `mac_in0`/`mac_in1` hold their last value when `mac_valid_input`=0.

## Timing
- Reset (asynchronous assert) puts the block in IDLE with all outputs 0: `in_ready`, `mac_in0`, `mac_in1`, `mac_valid_input`, `mac_clear_acc`, `out_valid`, `out_data`, `busy`, and `out_sat` when present. `count` and `len` are also 0. Reset mid-operation abandons the dot product; the MAC is cleared by its own reset or by the next CLEAR.
- `start` sampled at edge k → CLEAR in cycle k+1 → `in_ready`=1 from cycle k+2.
- Throughput is one pair per cycle while `in_valid` is held.
- Last pair accepted at edge k: `mac_valid_input`=1 in k+1, capture at end of k+2, `out_valid`=1 from k+3. Input-to-result latency is 3 cycles, independent of `len`.
- `out_valid` with `out_ready` at edge m → IDLE in m+1. A `start` is accepted at edge m+1 at the earliest.
- All outputs are registered.

## Configuration
- `MAC_SEQ_SATFLAG_EN` defined: adds output `out_sat` (1 bit). It is set with `out_data` at capture and equals 1 iff the captured value is +(2^(OUTW-1))-1 or -(2^(OUTW-1)). It is valid alongside `out_valid`.
- Not defined: the port and its logic are absent, and behaviour is otherwise identical.

## Test plan
- The bench drives the MAC's active-high `reset` with `~reset`.
- len=3, pairs (2,3),(4,5),(-1,7) back-to-back → `out_data`=19. `out_valid` rises 3 cycles after the third handshake and `mac_valid_input` pulses exactly 3 times.
- len=2, `in_valid` gapped (pair, 2 idle cycles, pair) with (100,-100),(7,7) → `out_data`=-9951. `in_ready` stays 1 through the gap.
- `cfg_len`=0 with pair (5,6) → treated as 1, `out_data`=30. A second `start` issued during OUT is ignored (`busy` stays 1, no CLEAR).
- With OUTW=32 and the macro defined, len=2, pairs (-32768,-32768) twice → `out_data`=2147483647, `out_sat`=1.
- `out_ready` held 0 for 5 cycles → `out_valid`/`out_data` stable. `out_ready`=1 → IDLE next cycle, and the next run (len=1, (3,4)) yields 12, proving the accumulator was cleared.
- Assert `reset`=0 mid-ACCUM after 2 of 4 pairs → all outputs 0 immediately. A new run with len=1 and (1,1) → `out_data`=1.

Source files
------------

// File: rtl/mac_seq.sv
// Operand sequencer and result collector for one saturating MAC instance.
// Optional `MAC_SEQ_SATFLAG_EN` adds out_sat, flagging a saturated captured result.
module mac_seq #(
    parameter  int INW    = 16,
    parameter  int OUTW   = 48,
    parameter  int MAXLEN = 256,
    localparam int LENW   = $clog2(MAXLEN + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [LENW-1:0]        cfg_len,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [INW-1:0]  in_a,
    input  logic signed [INW-1:0]  in_b,
    output logic signed [INW-1:0]  mac_in0,
    output logic signed [INW-1:0]  mac_in1,
    output logic                   mac_valid_input,
    output logic                   mac_clear_acc,
    input  logic signed [OUTW-1:0] mac_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [OUTW-1:0] out_data,
`ifdef MAC_SEQ_SATFLAG_EN
    output logic                   out_sat,
`endif
    output logic                   busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_FLUSH,
        S_CAPTURE,
        S_OUT
    } state_t;

    state_t                 r_state;
    logic [LENW-1:0]        r_len;
    logic [LENW-1:0]        r_count;
    logic                   r_in_ready;
    logic signed [INW-1:0]  r_mac_in0;
    logic signed [INW-1:0]  r_mac_in1;
    logic                   r_mac_valid;
    logic                   r_mac_clear;
    logic                   r_out_valid;
    logic signed [OUTW-1:0] r_out_data;
    logic                   r_busy;

    logic [LENW-1:0]        w_len;
    logic [LENW-1:0]        w_count_nxt;
    logic                   w_hs;

    // Zero-length requests run one pair; oversize requests are clamped.
    always_comb begin
        w_len = cfg_len;
        if (cfg_len == '0)
            w_len = LENW'(1);
        else if (cfg_len > LENW'(MAXLEN))
            w_len = LENW'(MAXLEN);
    end

    assign w_count_nxt = r_count + LENW'(1);
    assign w_hs        = r_in_ready & in_valid;

`ifdef MAC_SEQ_SATFLAG_EN
    logic r_out_sat;
    logic w_sat;

    assign w_sat = (mac_out == {1'b0, {(OUTW-1){1'b1}}}) ||
                   (mac_out == {1'b1, {(OUTW-1){1'b0}}});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_out_sat <= 1'b0;
        else if (r_state == S_CAPTURE)
            r_out_sat <= w_sat;
    end

    assign out_sat = r_out_sat;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b0;
            r_mac_in0   <= '0;
            r_mac_in1   <= '0;
            r_mac_valid <= 1'b0;
            r_mac_clear <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len       <= w_len;
                        r_count     <= '0;
                        r_mac_clear <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_mac_clear <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_ACCUM;
                end
                S_ACCUM: begin
                    if (w_hs) begin
                        r_mac_in0   <= in_a;
                        r_mac_in1   <= in_b;
                        r_mac_valid <= 1'b1;
                        r_count     <= w_count_nxt;
                        if (w_count_nxt == r_len) begin
                            r_in_ready <= 1'b0;
                            r_state    <= S_FLUSH;
                        end
                    end else begin
                        r_mac_valid <= 1'b0;
                    end
                end
                // Final pair is on the MAC inputs this cycle; clear is
                // pre-armed so it lands in the capture cycle.
                S_FLUSH: begin
                    r_mac_valid <= 1'b0;
                    r_mac_clear <= 1'b1;
                    r_state     <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_mac_clear <= 1'b0;
                    r_out_data  <= mac_out;
                    r_out_valid <= 1'b1;
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready        = r_in_ready;
    assign mac_in0         = r_mac_in0;
    assign mac_in1         = r_mac_in1;
    assign mac_valid_input = r_mac_valid;
    assign mac_clear_acc   = r_mac_clear;
    assign out_valid       = r_out_valid;
    assign out_data        = r_out_data;
    assign busy            = r_busy;

endmodule

// File: tb/tb_mac_seq.sv
// Directed bench for mac_seq with a behavioural saturating MAC attached.
module tb_mac_seq;

    localparam int INW    = 16;
    localparam int OUTW   = 32;
    localparam int MAXLEN = 256;
    localparam int LENW   = $clog2(MAXLEN + 1);

    localparam longint SMAX = (longint'(1) <<< (OUTW - 1)) - 1;
    localparam longint SMIN = -SMAX - 1;

    logic                   clk;
    logic                   reset;
    logic                   start;
    logic [LENW-1:0]        cfg_len;
    logic                   in_valid;
    logic                   in_ready;
    logic signed [INW-1:0]  in_a;
    logic signed [INW-1:0]  in_b;
    logic signed [INW-1:0]  mac_in0;
    logic signed [INW-1:0]  mac_in1;
    logic                   mac_valid_input;
    logic                   mac_clear_acc;
    logic signed [OUTW-1:0] mac_out;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [OUTW-1:0] out_data;
    logic                   busy;
`ifdef MAC_SEQ_SATFLAG_EN
    logic                   out_sat;
`endif

    int n_tests  = 0;
    int n_failed = 0;

    mac_seq #(
        .INW   (INW),
        .OUTW  (OUTW),
        .MAXLEN(MAXLEN)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .cfg_len        (cfg_len),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_a           (in_a),
        .in_b           (in_b),
        .mac_in0        (mac_in0),
        .mac_in1        (mac_in1),
        .mac_valid_input(mac_valid_input),
        .mac_clear_acc  (mac_clear_acc),
        .mac_out        (mac_out),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
`ifdef MAC_SEQ_SATFLAG_EN
        .out_sat        (out_sat),
`endif
        .busy           (busy)
    );

    // Reference MAC: active-high reset, clear wins, saturating accumulate.
    logic                   mac_rst;
    logic signed [OUTW-1:0] acc;
    longint                 sum;

    assign mac_rst = ~reset;
    assign mac_out = acc;

    always_comb sum = longint'(acc) + longint'(mac_in0) * longint'(mac_in1);

    always @(posedge clk or posedge mac_rst) begin
        if (mac_rst)
            acc <= '0;
        else if (mac_clear_acc)
            acc <= '0;
        else if (mac_valid_input)
            acc <= (sum > SMAX) ? OUTW'(SMAX) : (sum < SMIN) ? OUTW'(SMIN) : OUTW'(sum);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter plus negedge monitors for handshake, MAC strobe and out_valid rise.
    int   cyc          = 0;
    int   n_mvi        = 0;
    int   last_hs_edge = 0;
    int   ov_rise_cyc  = 0;
    logic ov_prev      = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mac_valid_input) n_mvi <= n_mvi + 1;
        if (in_valid && in_ready) last_hs_edge <= cyc + 1;
        if (out_valid && !ov_prev) ov_rise_cyc <= cyc;
        ov_prev <= out_valid;
    end

    task automatic check_eq(input string tag, input logic signed [63:0] got,
                            input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_in_ready"}, 64'(in_ready), 0);
        check_eq({tag, "_mac_in0"}, 64'(mac_in0), 0);
        check_eq({tag, "_mac_in1"}, 64'(mac_in1), 0);
        check_eq({tag, "_mac_valid"}, 64'(mac_valid_input), 0);
        check_eq({tag, "_mac_clear"}, 64'(mac_clear_acc), 0);
        check_eq({tag, "_out_valid"}, 64'(out_valid), 0);
        check_eq({tag, "_out_data"}, 64'(out_data), 0);
        check_eq({tag, "_busy"}, 64'(busy), 0);
`ifdef MAC_SEQ_SATFLAG_EN
        check_eq({tag, "_out_sat"}, 64'(out_sat), 0);
`endif
    endtask

    task automatic do_start(input int len);
        @(negedge clk);
        start   = 1'b1;
        cfg_len = LENW'(len);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send(input int a, input int b);
        bit ok;
        ok       = 1'b0;
        in_a     = INW'(a);
        in_b     = INW'(b);
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) check_eq("send_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (out_valid) ok = 1'b1;
        end
        if (!ok) check_eq({tag, "_timeout"}, 0, 1);
        #1;
    endtask

    task automatic accept_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset     = 1'b0;
        start     = 1'b0;
        cfg_len   = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;

        #2;
        check_idle_outputs("reset");
        @(negedge clk);
        reset = 1'b1;

        // Back-to-back: 2*3 + 4*5 - 7 = 19
        base = n_mvi;
        do_start(3);
        send(2, 3);
        send(4, 5);
        send(-1, 7);
        wait_out("t1");
        check_eq("t1_data", 64'(out_data), 19);
        // Cycles counted from the one that follows the accepting edge.
        check_eq("t1_latency", 64'(ov_rise_cyc - last_hs_edge + 1), 3);
        check_eq("t1_mvi_pulses", 64'(n_mvi - base), 3);
`ifdef MAC_SEQ_SATFLAG_EN
        check_eq("t1_sat", 64'(out_sat), 0);
`endif
        accept_out();

        // Gapped input: -10000 + 49 = -9951
        base = n_mvi;
        do_start(2);
        send(100, -100);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("t2_ready_gap", 64'(in_ready), 1);
        end
        @(posedge clk);
        #1;
        send(7, 7);
        wait_out("t2");
        check_eq("t2_data", 64'(out_data), -9951);
        check_eq("t2_mvi_pulses", 64'(n_mvi - base), 2);
        accept_out();

        // cfg_len=0 runs one pair; start during OUT ignored while out_ready held low.
        do_start(0);
        send(5, 6);
        wait_out("t3");
        check_eq("t3_data", 64'(out_data), 30);
        start   = 1'b1;
        cfg_len = LENW'(1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("t3_hold_valid", 64'(out_valid), 1);
            check_eq("t3_hold_data", 64'(out_data), 30);
            check_eq("t3_hold_busy", 64'(busy), 1);
            check_eq("t3_no_clear", 64'(mac_clear_acc), 0);
        end
        start = 1'b0;
        accept_out();
        @(negedge clk);
        check_eq("t3_idle_busy", 64'(busy), 0);
        check_eq("t3_idle_valid", 64'(out_valid), 0);

        do_start(1);
        send(3, 4);
        wait_out("t5");
        check_eq("t5_data", 64'(out_data), 12);
        accept_out();

        // Two 2^30 products overflow a 32-bit accumulator: positive saturation.
        do_start(2);
        send(-32768, -32768);
        send(-32768, -32768);
        wait_out("t4");
        check_eq("t4_data", 64'(out_data), 2147483647);
`ifdef MAC_SEQ_SATFLAG_EN
        check_eq("t4_sat", 64'(out_sat), 1);
`endif
        accept_out();

        // Reset mid-accumulation, then a fresh single-pair run.
        do_start(4);
        send(1, 2);
        send(3, 4);
        check_eq("t6_pre_busy", 64'(busy), 1);
        reset = 1'b0;
        #1;
        check_idle_outputs("t6_reset");
        @(negedge clk);
        reset = 1'b1;
        do_start(1);
        send(1, 1);
        wait_out("t6");
        check_eq("t6_data", 64'(out_data), 1);
        accept_out();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
